uart_fifo_core: RTL and testbench

//   Full-duplex UART with parametrised TX/RX FIFOs and runtime-programmable baud divisor and stop bits.

---
 rtl/uart_fifo_core.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with TX/RX FIFOs, runtime baud divisor and
// stop-bit selection, sticky frame/overrun error flags.
// Optional feature macro: UART_PARITY_EN adds a parity bit (even/odd chosen by
// parity_odd) after the data bits in both directions.
module uart_fifo_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         tx_din,
  input  logic                          wr_uart,
  input  logic                          rd_uart,
  output logic [DATA_WIDTH-1:0]         rx_dout,
  input  logic                          rx,
  output logic                          tx,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          stop_bits,
  input  logic                          parity_odd,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_cnt,
  output logic                          tx_fifo_empty,
  output logic                          tx_fifo_full,
  output logic                          rx_fifo_empty,
  output logic                          rx_fifo_full,
  output logic                          rx_frame_err,
  output logic                          rx_overrun,
  output logic                          rx_parity_err
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned NW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA,
`ifdef UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // ---------------- baud tick ----------------
  logic [DIV_WIDTH-1:0] r_baud_cnt;
  logic                 w_tick;
  assign w_tick = (r_baud_cnt == baud_div);

  // Free-running divisor counter, restarts at 0 after reaching baud_div
  always_ff @(posedge clk) begin
    if (rst || w_tick) r_baud_cnt <= '0;
    else               r_baud_cnt <= r_baud_cnt + DIV_WIDTH'(1);
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] r_txf_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_txf_wp, r_txf_rp;
  logic [CW-1:0]         r_txf_cnt;
  logic                  w_txf_push, w_tx_load;
  logic [DATA_WIDTH-1:0] w_txf_head;

  assign tx_fifo_cnt   = r_txf_cnt;
  assign tx_fifo_empty = (r_txf_cnt == '0);
  assign tx_fifo_full  = (r_txf_cnt == CW'(FIFO_DEPTH));
  assign w_txf_push    = wr_uart && !tx_fifo_full;
  assign w_txf_head    = r_txf_mem[r_txf_rp];

  // TX FIFO storage write
  always_ff @(posedge clk) begin
    if (w_txf_push) r_txf_mem[r_txf_wp] <= tx_din;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txf_wp <= '0; r_txf_rp <= '0; r_txf_cnt <= '0;
    end else begin
      if (w_txf_push) r_txf_wp <= r_txf_wp + AW'(1);
      if (w_tx_load)  r_txf_rp <= r_txf_rp + AW'(1);
      case ({w_txf_push, w_tx_load})
        2'b10:   r_txf_cnt <= r_txf_cnt + CW'(1);
        2'b01:   r_txf_cnt <= r_txf_cnt - CW'(1);
        default: r_txf_cnt <= r_txf_cnt;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_WIDTH-1:0] r_rxf_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_rxf_wp, r_rxf_rp;
  logic [CW-1:0]         r_rxf_cnt;
  logic                  w_rxf_pop, w_rx_push;
  logic [DATA_WIDTH-1:0] r_rx_shift;

  assign rx_fifo_cnt   = r_rxf_cnt;
  assign rx_fifo_empty = (r_rxf_cnt == '0);
  assign rx_fifo_full  = (r_rxf_cnt == CW'(FIFO_DEPTH));
  assign w_rxf_pop     = rd_uart && !rx_fifo_empty;
  assign rx_dout       = rx_fifo_empty ? '0 : r_rxf_mem[r_rxf_rp];

  // RX FIFO storage write (shift register holds the completed character)
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rxf_mem[r_rxf_wp] <= r_rx_shift;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxf_wp <= '0; r_rxf_rp <= '0; r_rxf_cnt <= '0;
    end else begin
      if (w_rx_push) r_rxf_wp <= r_rxf_wp + AW'(1);
      if (w_rxf_pop) r_rxf_rp <= r_rxf_rp + AW'(1);
      case ({w_rx_push, w_rxf_pop})
        2'b10:   r_rxf_cnt <= r_rxf_cnt + CW'(1);
        2'b01:   r_rxf_cnt <= r_rxf_cnt - CW'(1);
        default: r_rxf_cnt <= r_rxf_cnt;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  state_t                r_tx_state, w_tx_state_n;
  logic [SW-1:0]         r_tx_tcnt, w_tx_tcnt_n;
  logic [NW-1:0]         r_tx_bcnt, w_tx_bcnt_n;
  logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_shift_n;
  logic                  r_tx_stop2, w_tx_stop2_n;
  logic                  r_tx, w_tx_n;
`ifdef UART_PARITY_EN
  logic                  r_tx_par, w_tx_par_n;
`endif

  assign tx = r_tx;

  // TX state and datapath registers; tx pin is registered from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= ST_IDLE; r_tx_tcnt <= '0; r_tx_bcnt <= '0;
      r_tx_shift <= '0; r_tx_stop2 <= 1'b0; r_tx <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      r_tx_state <= w_tx_state_n; r_tx_tcnt <= w_tx_tcnt_n; r_tx_bcnt <= w_tx_bcnt_n;
      r_tx_shift <= w_tx_shift_n; r_tx_stop2 <= w_tx_stop2_n; r_tx <= w_tx_n;
`ifdef UART_PARITY_EN
      r_tx_par   <= w_tx_par_n;
`endif
    end
  end

  // TX next-state: bit timing in ticks, FIFO pop on character start
  always_comb begin
    w_tx_state_n = r_tx_state; w_tx_tcnt_n = r_tx_tcnt; w_tx_bcnt_n = r_tx_bcnt;
    w_tx_shift_n = r_tx_shift; w_tx_stop2_n = r_tx_stop2; w_tx_load = 1'b0;
`ifdef UART_PARITY_EN
    w_tx_par_n   = r_tx_par;
`endif
    case (r_tx_state)
      ST_IDLE: w_tx_load = !tx_fifo_empty;
      ST_START: if (w_tick) begin
        if (r_tx_tcnt == SW'(OVERSAMPLE-1)) begin
          w_tx_tcnt_n = '0; w_tx_bcnt_n = '0; w_tx_state_n = ST_DATA;
        end else w_tx_tcnt_n = r_tx_tcnt + SW'(1);
      end
      ST_DATA: if (w_tick) begin
        if (r_tx_tcnt == SW'(OVERSAMPLE-1)) begin
          w_tx_tcnt_n  = '0;
          w_tx_shift_n = r_tx_shift >> 1;
          if (r_tx_bcnt == NW'(DATA_WIDTH-1)) begin
            w_tx_bcnt_n = '0;
`ifdef UART_PARITY_EN
            w_tx_state_n = ST_PARITY;
`else
            w_tx_state_n = ST_STOP;
`endif
          end else w_tx_bcnt_n = r_tx_bcnt + NW'(1);
        end else w_tx_tcnt_n = r_tx_tcnt + SW'(1);
      end
`ifdef UART_PARITY_EN
      ST_PARITY: if (w_tick) begin
        if (r_tx_tcnt == SW'(OVERSAMPLE-1)) begin
          w_tx_tcnt_n = '0; w_tx_state_n = ST_STOP;
        end else w_tx_tcnt_n = r_tx_tcnt + SW'(1);
      end
`endif
      ST_STOP: if (w_tick) begin
        if (r_tx_tcnt == SW'(OVERSAMPLE-1)) begin
          w_tx_tcnt_n = '0;
          if (r_tx_stop2 && r_tx_bcnt == '0) w_tx_bcnt_n = NW'(1);
          else begin
            // Chain straight into the next start bit so there is no idle gap
            w_tx_state_n = ST_IDLE;
            w_tx_load    = !tx_fifo_empty;
          end
        end else w_tx_tcnt_n = r_tx_tcnt + SW'(1);
      end
      default: w_tx_state_n = ST_IDLE;
    endcase
    if (w_tx_load) begin
      w_tx_state_n = ST_START; w_tx_tcnt_n = '0;
      w_tx_shift_n = w_txf_head; w_tx_stop2_n = stop_bits;
`ifdef UART_PARITY_EN
      w_tx_par_n   = (^w_txf_head) ^ parity_odd;
`endif
    end
    case (w_tx_state_n)
      ST_START:  w_tx_n = 1'b0;
      ST_DATA:   w_tx_n = w_tx_shift_n[0];
`ifdef UART_PARITY_EN
      ST_PARITY: w_tx_n = w_tx_par_n;
`endif
      default:   w_tx_n = 1'b1;
    endcase
  end

  // ---------------- RX FSM ----------------
  logic                  r_rx_s1, r_rx_s2, r_rx_prev;
  state_t                r_rx_state, w_rx_state_n;
  logic [SW-1:0]         r_rx_tcnt, w_rx_tcnt_n;
  logic [NW-1:0]         r_rx_bcnt, w_rx_bcnt_n;
  logic [DATA_WIDTH-1:0] w_rx_shift_n;
  logic                  w_set_frame, w_set_ovr;
`ifdef UART_PARITY_EN
  logic                  r_rx_podd, w_rx_podd_n, w_set_par, r_parity_err;
`endif

  // Input synchroniser, edge history and RX state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_prev <= 1'b1;
      r_rx_state <= ST_IDLE; r_rx_tcnt <= '0; r_rx_bcnt <= '0; r_rx_shift <= '0;
`ifdef UART_PARITY_EN
      r_rx_podd <= 1'b0;
`endif
    end else begin
      r_rx_s1 <= rx; r_rx_s2 <= r_rx_s1; r_rx_prev <= r_rx_s2;
      r_rx_state <= w_rx_state_n; r_rx_tcnt <= w_rx_tcnt_n;
      r_rx_bcnt <= w_rx_bcnt_n; r_rx_shift <= w_rx_shift_n;
`ifdef UART_PARITY_EN
      r_rx_podd <= w_rx_podd_n;
`endif
    end
  end

  // RX next-state: start validation at half bit, then mid-bit sampling.
  // The character is pushed at the stop-bit sample so the FSM is back in IDLE
  // before the next start edge can arrive.
  always_comb begin
    w_rx_state_n = r_rx_state; w_rx_tcnt_n = r_rx_tcnt; w_rx_bcnt_n = r_rx_bcnt;
    w_rx_shift_n = r_rx_shift; w_rx_push = 1'b0; w_set_frame = 1'b0; w_set_ovr = 1'b0;
`ifdef UART_PARITY_EN
    w_rx_podd_n  = r_rx_podd; w_set_par = 1'b0;
`endif
    case (r_rx_state)
      ST_IDLE: if (r_rx_prev && !r_rx_s2) begin
        w_rx_state_n = ST_START; w_rx_tcnt_n = '0;
`ifdef UART_PARITY_EN
        w_rx_podd_n  = parity_odd;
`endif
      end
      ST_START: if (w_tick) begin
        if (r_rx_tcnt == SW'(OVERSAMPLE/2-1)) begin
          w_rx_tcnt_n = '0; w_rx_bcnt_n = '0;
          w_rx_state_n = r_rx_s2 ? ST_IDLE : ST_DATA;
        end else w_rx_tcnt_n = r_rx_tcnt + SW'(1);
      end
      ST_DATA: if (w_tick) begin
        if (r_rx_tcnt == SW'(OVERSAMPLE-1)) begin
          w_rx_tcnt_n  = '0;
          w_rx_shift_n = {r_rx_s2, r_rx_shift[DATA_WIDTH-1:1]};
          if (r_rx_bcnt == NW'(DATA_WIDTH-1)) begin
`ifdef UART_PARITY_EN
            w_rx_state_n = ST_PARITY;
`else
            w_rx_state_n = ST_STOP;
`endif
          end else w_rx_bcnt_n = r_rx_bcnt + NW'(1);
        end else w_rx_tcnt_n = r_rx_tcnt + SW'(1);
      end
`ifdef UART_PARITY_EN
      ST_PARITY: if (w_tick) begin
        if (r_rx_tcnt == SW'(OVERSAMPLE-1)) begin
          w_rx_tcnt_n  = '0; w_rx_state_n = ST_STOP;
          w_set_par    = (r_rx_s2 != ((^r_rx_shift) ^ r_rx_podd));
        end else w_rx_tcnt_n = r_rx_tcnt + SW'(1);
      end
`endif
      ST_STOP: if (w_tick) begin
        if (r_rx_tcnt == SW'(OVERSAMPLE-1)) begin
          w_rx_tcnt_n  = '0; w_rx_state_n = ST_IDLE;
          w_set_frame  = !r_rx_s2;
          w_set_ovr    = rx_fifo_full;
          w_rx_push    = !rx_fifo_full;
        end else w_rx_tcnt_n = r_rx_tcnt + SW'(1);
      end
      default: w_rx_state_n = ST_IDLE;
    endcase
  end

  // Sticky error flags; a new error wins over err_clr in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_frame_err <= 1'b0; rx_overrun <= 1'b0;
    end else begin
      if (w_set_frame)  rx_frame_err <= 1'b1;
      else if (err_clr) rx_frame_err <= 1'b0;
      if (w_set_ovr)    rx_overrun   <= 1'b1;
      else if (err_clr) rx_overrun   <= 1'b0;
    end
  end

`ifdef UART_PARITY_EN
  // Sticky parity error flag
  always_ff @(posedge clk) begin
    if (rst)            r_parity_err <= 1'b0;
    else if (w_set_par) r_parity_err <= 1'b1;
    else if (err_clr)   r_parity_err <= 1'b0;
  end
  assign rx_parity_err = r_parity_err;
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = parity_odd;
  assign rx_parity_err       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed self-checking bench for uart_fifo_core (8 data bits, 16-deep FIFOs,
// 16x oversampling, baud_div=0 so one bit lasts 16 clk).
module tb_uart_fifo_core;
`ifdef UART_PARITY_EN
  localparam int PB = 16;
`else
  localparam int PB = 0;
`endif

  logic       clk, rst;
  logic [7:0] tx_din, rx_dout;
  logic       wr_uart, rd_uart, rx, tx;
  logic [15:0] baud_div;
  logic       stop_bits, parity_odd, err_clr;
  logic [4:0] tx_fifo_cnt, rx_fifo_cnt;
  logic       tx_fifo_empty, tx_fifo_full, rx_fifo_empty, rx_fifo_full;
  logic       rx_frame_err, rx_overrun, rx_parity_err;
  logic       loop_en, rx_drv;
  int         checks, errors;

  assign rx = loop_en ? tx : rx_drv;

  uart_fifo_core #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .DIV_WIDTH(16), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .tx_din(tx_din), .wr_uart(wr_uart), .rd_uart(rd_uart),
    .rx_dout(rx_dout), .rx(rx), .tx(tx), .baud_div(baud_div), .stop_bits(stop_bits),
    .parity_odd(parity_odd), .err_clr(err_clr), .tx_fifo_cnt(tx_fifo_cnt),
    .rx_fifo_cnt(rx_fifo_cnt), .tx_fifo_empty(tx_fifo_empty), .tx_fifo_full(tx_fifo_full),
    .rx_fifo_empty(rx_fifo_empty), .rx_fifo_full(rx_fifo_full),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .rx_parity_err(rx_parity_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(2); rst = 1'b0;
  endtask

  // Drive one frame on rx_drv; parity (if compiled in) is correct unless flip=1
  task automatic send_rx(input logic [7:0] d, input logic stopv, input logic flip);
    rx_drv = 1'b0; step(16);
    for (int k = 0; k < 8; k++) begin rx_drv = d[k]; step(16); end
`ifdef UART_PARITY_EN
    rx_drv = (^d) ^ parity_odd ^ flip; step(16);
`else
    if (flip) rx_drv = 1'b1;
`endif
    rx_drv = stopv; step(16);
    rx_drv = 1'b1;  step(16);
  endtask

  task automatic test_reset();
    rst = 1'b1; step(2);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
    checks++; if (tx_fifo_cnt !== 5'd0 || rx_fifo_cnt !== 5'd0) begin errors++;
      $display("FAIL reset_cnt got tx=%0d rx=%0d exp 0/0", tx_fifo_cnt, rx_fifo_cnt); end
    checks++; if ({tx_fifo_empty, rx_fifo_empty, tx_fifo_full, rx_fifo_full} !== 4'b1100) begin errors++;
      $display("FAIL reset_flags got %b exp 1100", {tx_fifo_empty, rx_fifo_empty, tx_fifo_full, rx_fifo_full}); end
    checks++; if ({rx_frame_err, rx_overrun, rx_parity_err} !== 3'b000 || rx_dout !== 8'h00) begin errors++;
      $display("FAIL reset_err got err=%b dout=%h exp 000/00", {rx_frame_err, rx_overrun, rx_parity_err}, rx_dout); end
    rst = 1'b0;
  endtask

  task automatic test_loopback();
    logic [7:0] b;
    int t;
    b = 8'hA5; loop_en = 1'b1; do_reset();
    wr_uart = 1'b1; tx_din = b; step(1); wr_uart = 1'b0;
    checks++; if (tx !== 1'b1 || tx_fifo_cnt !== 5'd1) begin errors++;
      $display("FAIL lb_push got tx=%b cnt=%0d exp 1/1", tx, tx_fifo_cnt); end
    step(1);
    checks++; if (tx !== 1'b0 || tx_fifo_empty !== 1'b1) begin errors++;
      $display("FAIL lb_start got tx=%b empty=%b exp 0/1", tx, tx_fifo_empty); end
    step(8);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL lb_start_mid got %b exp 0", tx); end
    for (int k = 0; k < 8; k++) begin
      step(16);
      checks++; if (tx !== b[k]) begin errors++; $display("FAIL lb_bit%0d got %b exp %b", k, tx, b[k]); end
    end
    step(16 + PB);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL lb_stop got %b exp 1", tx); end
    t = 0;
    while (rx_fifo_empty && t < 100) begin step(1); t++; end
    checks++; if (rx_fifo_cnt !== 5'd1 || rx_dout !== 8'hA5) begin errors++;
      $display("FAIL lb_rx got cnt=%0d dout=%h exp 1/a5", rx_fifo_cnt, rx_dout); end
    rd_uart = 1'b1; step(1); rd_uart = 1'b0;
    checks++; if (rx_fifo_empty !== 1'b1 || rx_dout !== 8'h00 || rx_frame_err !== 1'b0) begin errors++;
      $display("FAIL lb_pop got empty=%b dout=%h ferr=%b exp 1/00/0", rx_fifo_empty, rx_dout, rx_frame_err); end
  endtask

  task automatic test_two_stop_back_to_back();
    loop_en = 1'b0; stop_bits = 1'b1; do_reset();
    wr_uart = 1'b1; tx_din = 8'hFF; step(1); tx_din = 8'hFE; step(1); wr_uart = 1'b0;
    step(175 + PB);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL stop2_last got %b exp 1", tx); end
    step(1);
    checks++; if (tx !== 1'b0 || tx_fifo_empty !== 1'b1) begin errors++;
      $display("FAIL b2b_start got tx=%b empty=%b exp 0/1", tx, tx_fifo_empty); end
    stop_bits = 1'b0;
  endtask

  task automatic test_tx_fifo_fill();
    loop_en = 1'b0; baud_div = 16'hFFFF; do_reset();
    for (int i = 0; i < 18; i++) begin
      wr_uart = 1'b1; tx_din = 8'(i + 1); step(1);
      if (i == 1) begin
        checks++; if (tx !== 1'b0 || tx_fifo_cnt !== 5'd1) begin errors++;
          $display("FAIL fill_first_pop got tx=%b cnt=%0d exp 0/1", tx, tx_fifo_cnt); end
      end
      if (i == 15) begin
        checks++; if (tx_fifo_cnt !== 5'd15 || tx_fifo_full !== 1'b0) begin errors++;
          $display("FAIL fill_15 got cnt=%0d full=%b exp 15/0", tx_fifo_cnt, tx_fifo_full); end
      end
      if (i == 16) begin
        checks++; if (tx_fifo_cnt !== 5'd16 || tx_fifo_full !== 1'b1) begin errors++;
          $display("FAIL fill_16 got cnt=%0d full=%b exp 16/1", tx_fifo_cnt, tx_fifo_full); end
      end
    end
    wr_uart = 1'b0;
    checks++; if (tx_fifo_cnt !== 5'd16 || tx_fifo_full !== 1'b1) begin errors++;
      $display("FAIL fill_18th_ignored got cnt=%0d full=%b exp 16/1", tx_fifo_cnt, tx_fifo_full); end
    baud_div = 16'h0000; do_reset();
  endtask

  task automatic test_overrun();
    int t;
    loop_en = 1'b1; do_reset();
    for (int i = 0; i < 17; i++) begin
      wr_uart = 1'b1; tx_din = (i < 16) ? 8'(8'h10 + i) : 8'h3C; step(1);
    end
    wr_uart = 1'b0;
    t = 0;
    while (!rx_overrun && t < 4000) begin step(1); t++; end
    checks++; if (rx_overrun !== 1'b1 || rx_fifo_cnt !== 5'd16 || rx_fifo_full !== 1'b1) begin errors++;
      $display("FAIL ovr_set got ovr=%b cnt=%0d full=%b exp 1/16/1", rx_overrun, rx_fifo_cnt, rx_fifo_full); end
    checks++; if (rx_dout !== 8'h10 || rx_frame_err !== 1'b0) begin errors++;
      $display("FAIL ovr_head got dout=%h ferr=%b exp 10/0", rx_dout, rx_frame_err); end
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b exp 0", rx_overrun); end
    rd_uart = 1'b1; step(1); rd_uart = 1'b0;
    checks++; if (rx_dout !== 8'h11 || rx_fifo_cnt !== 5'd15) begin errors++;
      $display("FAIL ovr_pop got dout=%h cnt=%0d exp 11/15", rx_dout, rx_fifo_cnt); end
  endtask

  task automatic test_frame_err();
    loop_en = 1'b0; rx_drv = 1'b1; do_reset();
    send_rx(8'h55, 1'b0, 1'b0);
    checks++; if (rx_frame_err !== 1'b1 || rx_fifo_cnt !== 5'd1 || rx_dout !== 8'h55) begin errors++;
      $display("FAIL ferr_set got ferr=%b cnt=%0d dout=%h exp 1/1/55", rx_frame_err, rx_fifo_cnt, rx_dout); end
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clr got %b exp 0", rx_frame_err); end
    send_rx(8'h96, 1'b1, 1'b0);
    checks++; if (rx_frame_err !== 1'b0 || rx_fifo_cnt !== 5'd2 || rx_dout !== 8'h55) begin errors++;
      $display("FAIL ferr_good got ferr=%b cnt=%0d dout=%h exp 0/2/55", rx_frame_err, rx_fifo_cnt, rx_dout); end
    rd_uart = 1'b1; step(1); rd_uart = 1'b0;
    checks++; if (rx_dout !== 8'h96 || rx_fifo_cnt !== 5'd1) begin errors++;
      $display("FAIL ferr_pop got dout=%h cnt=%0d exp 96/1", rx_dout, rx_fifo_cnt); end
  endtask

  task automatic test_glitch();
    loop_en = 1'b0; rx_drv = 1'b1; do_reset();
    rx_drv = 1'b0; step(4); rx_drv = 1'b1; step(100);
    checks++; if (rx_fifo_cnt !== 5'd0 || rx_frame_err !== 1'b0) begin errors++;
      $display("FAIL glitch got cnt=%0d ferr=%b exp 0/0", rx_fifo_cnt, rx_frame_err); end
    send_rx(8'hC3, 1'b1, 1'b0);
    checks++; if (rx_fifo_cnt !== 5'd1 || rx_dout !== 8'hC3) begin errors++;
      $display("FAIL glitch_recover got cnt=%0d dout=%h exp 1/c3", rx_fifo_cnt, rx_dout); end
  endtask

  task automatic test_reset_midframe();
    loop_en = 1'b1; do_reset();
    wr_uart = 1'b1; tx_din = 8'h00; step(1); wr_uart = 1'b0;
    step(40);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_active got %b exp 0", tx); end
    rst = 1'b1; step(1);
    checks++; if (tx !== 1'b1 || tx_fifo_empty !== 1'b1) begin errors++;
      $display("FAIL mid_abort got tx=%b empty=%b exp 1/1", tx, tx_fifo_empty); end
    rst = 1'b0; step(300);
    checks++; if (rx_fifo_empty !== 1'b1 || tx !== 1'b1) begin errors++;
      $display("FAIL mid_discard got rxempty=%b tx=%b exp 1/1", rx_fifo_empty, tx); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    int t;
    parity_odd = 1'b1; loop_en = 1'b1; do_reset();
    wr_uart = 1'b1; tx_din = 8'h07; step(1); wr_uart = 1'b0;
    step(1); step(152);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL par_bit got %b exp 0", tx); end
    step(16);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL par_stop got %b exp 1", tx); end
    t = 0;
    while (rx_fifo_empty && t < 100) begin step(1); t++; end
    checks++; if (rx_parity_err !== 1'b0 || rx_dout !== 8'h07) begin errors++;
      $display("FAIL par_good got perr=%b dout=%h exp 0/07", rx_parity_err, rx_dout); end
    loop_en = 1'b0; rx_drv = 1'b1; step(20);
    send_rx(8'h07, 1'b1, 1'b1);
    checks++; if (rx_parity_err !== 1'b1 || rx_fifo_cnt !== 5'd2) begin errors++;
      $display("FAIL par_bad got perr=%b cnt=%0d exp 1/2", rx_parity_err, rx_fifo_cnt); end
    parity_odd = 1'b0;
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; tx_din = '0; wr_uart = 1'b0; rd_uart = 1'b0; baud_div = '0;
    stop_bits = 1'b0; parity_odd = 1'b0; err_clr = 1'b0; loop_en = 1'b0; rx_drv = 1'b1;
    test_reset();
    test_loopback();
    test_two_stop_back_to_back();
    test_tx_fifo_fill();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
